// File: rtl/sitcp_frame_checker.sv
// sitcp_frame_checker
//   Read-side consumer of the 8-bit SiTCP byte-stream FIFO. Pulls bytes while
//   the FIFO is non-empty, parses header (10 B) / hit words (5 B each) /
//   footer (10 B), emits decoded hits and per-frame summaries, and flags
//   framing, footer/header, length and event-sequence errors.
//
//   Optional feature macro: FRAME_CHECK_SEQ_EN (event-number sequence check,
//   ERR 4). Without it ERR 4 is never produced.
//
// Ports
//   Clk, Rst            read clock, synchronous active-low reset
//   Enable              1 = read FIFO, 0 = hold FifoRdEnb low (state kept)
//   ClrCounters         clears FrameCount, ErrCount and the sequence reference
//   FifoRdData/Empty/Valid, FifoRdEnb   FIFO read port
//   HitValid + Hit*     decoded hit word, pulse + held fields
//   FrameDone, FrameOk, FrameEventNumber, FrameDataLength   frame summary
//   ErrPulse, ErrCode   one pulse per error cycle, lowest code wins
//   FrameCount, ErrCount  wrapping frame counter, saturating error counter
//
// State | meaning
//   HUNT | discard bytes until a header lead (2'b10) appears
//   HDR  | collecting header bytes 1..9 into the shadow
//   DATA | hit words, or footer byte 0 at index 0
//   FTR  | footer bytes 1..9, compared against the header shadow

module sitcp_frame_checker (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic        ClrCounters,
  input  logic [7:0]  FifoRdData,
  input  logic        FifoEmpty,
  input  logic        FifoValid,
  output logic        FifoRdEnb,
  output logic        HitValid,
  output logic [4:0]  HitAsicId,
  output logic [6:0]  HitChannelId,
  output logic [12:0] HitLeading,
  output logic [12:0] HitTrailing,
  output logic [23:0] HitEventNumber,
  output logic        FrameDone,
  output logic        FrameOk,
  output logic [23:0] FrameEventNumber,
  output logic [23:0] FrameDataLength,
  output logic        ErrPulse,
  output logic [2:0]  ErrCode,
  output logic [31:0] FrameCount,
  output logic [15:0] ErrCount
);

  typedef enum logic [1:0] {HUNT, HDR, DATA, FTR} state_t;

  state_t       state, state_n;
  logic [3:0]   idx, idx_n;
  logic [79:0]  shadow;
  logic [29:0]  hit_sh;
  logic [23:0]  word_cnt;
  logic         ovf_seen;
  logic         frame_err;
  logic         ftr_mis_q, mis_n;

  logic         hit_fire, ftr_fire, err1, err5, hdr_latch, shadow_shift;
  logic         e2, e3, e4, err_any;
  logic [2:0]   err_code;
  logic [1:0]   lead;
  logic [3:0]   ftr_pos;
  logic [7:0]   shadow_byte;
  logic [37:0]  hit_word;
  logic [23:0]  hdr_len, hdr_evt;

  assign FifoRdEnb = Rst & Enable & ~FifoEmpty;

  assign lead     = FifoRdData[7:6];
  assign hdr_len  = shadow[23:0];
  assign hdr_evt  = shadow[48:25];
  assign hit_word = {hit_sh, FifoRdData};

  // Header byte k sits at shadow[8*(9-k) +: 8]; footer byte 0 arrives with
  // idx=0, which selects the top byte.
  assign ftr_pos     = 4'd9 - idx;
  assign shadow_byte = shadow[{ftr_pos, 3'b000} +: 8];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= HUNT;
      idx   <= 4'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    hit_fire     = 1'b0;
    ftr_fire     = 1'b0;
    err1         = 1'b0;
    err5         = 1'b0;
    hdr_latch    = 1'b0;
    shadow_shift = 1'b0;
    mis_n        = ftr_mis_q;
    if (FifoValid) begin
      case (state)
        HUNT: begin
          // Shifting every byte is harmless: ten shifts starting at header
          // byte 0 overwrite the whole shadow.
          shadow_shift = 1'b1;
          if (lead == 2'b10) begin
            state_n = HDR;
            idx_n   = 4'd1;
          end
        end
        HDR: begin
          shadow_shift = 1'b1;
          if (idx == 4'd9) begin
            hdr_latch = 1'b1;
            state_n   = DATA;
            idx_n     = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
        DATA: begin
          if (idx == 4'd0) begin
            case (lead)
              2'b00: begin
                idx_n = 4'd1;
                err5  = (word_cnt == hdr_len) && !ovf_seen;
              end
              2'b11: begin
                state_n = FTR;
                idx_n   = 4'd1;
                mis_n   = (FifoRdData[5:0] != shadow_byte[5:0]);
              end
              2'b10: begin
                err1         = 1'b1;
                shadow_shift = 1'b1;
                state_n      = HDR;
                idx_n        = 4'd1;
              end
              default: begin
                err1    = 1'b1;
                state_n = HUNT;
                idx_n   = 4'd0;
              end
            endcase
          end else if (idx == 4'd4) begin
            hit_fire = 1'b1;
            idx_n    = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
        default: begin
          mis_n = ftr_mis_q | (FifoRdData != shadow_byte);
          if (idx == 4'd9) begin
            ftr_fire = 1'b1;
            state_n  = HUNT;
            idx_n    = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef FRAME_CHECK_SEQ_EN
  logic        have_ref;
  logic [23:0] ref_evt;

  assign e4 = ftr_fire & have_ref & (hdr_evt != (ref_evt + 24'd1));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      have_ref <= 1'b0;
      ref_evt  <= 24'd0;
    end else if (ClrCounters) begin
      have_ref <= 1'b0;
      ref_evt  <= 24'd0;
    end else if (ftr_fire) begin
      have_ref <= 1'b1;
      ref_evt  <= hdr_evt;
    end
  end
`else
  assign e4 = 1'b0;
`endif

  assign e2      = ftr_fire & mis_n;
  assign e3      = ftr_fire & (word_cnt != hdr_len);
  assign err_any = err1 | e2 | e3 | e4 | err5;

  always_comb begin
    err_code = 3'd0;
    if (err1)      err_code = 3'd1;
    else if (e2)   err_code = 3'd2;
    else if (e3)   err_code = 3'd3;
    else if (e4)   err_code = 3'd4;
    else if (err5) err_code = 3'd5;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      shadow           <= 80'd0;
      hit_sh           <= 30'd0;
      word_cnt         <= 24'd0;
      ovf_seen         <= 1'b0;
      frame_err        <= 1'b0;
      ftr_mis_q        <= 1'b0;
      HitValid         <= 1'b0;
      HitAsicId        <= 5'd0;
      HitChannelId     <= 7'd0;
      HitLeading       <= 13'd0;
      HitTrailing      <= 13'd0;
      HitEventNumber   <= 24'd0;
      FrameDone        <= 1'b0;
      FrameOk          <= 1'b0;
      FrameEventNumber <= 24'd0;
      FrameDataLength  <= 24'd0;
      ErrPulse         <= 1'b0;
      ErrCode          <= 3'd0;
      FrameCount       <= 32'd0;
      ErrCount         <= 16'd0;
    end else begin
      if (shadow_shift) shadow <= {shadow[71:0], FifoRdData};
      if (FifoValid && state == DATA) hit_sh <= {hit_sh[21:0], FifoRdData};
      ftr_mis_q <= mis_n;

      if (hdr_latch) begin
        word_cnt  <= 24'd0;
        ovf_seen  <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (hit_fire) word_cnt <= word_cnt + 24'd1;
        if (err5) begin
          ovf_seen  <= 1'b1;
          frame_err <= 1'b1;
        end
      end

      HitValid <= hit_fire;
      if (hit_fire) begin
        HitAsicId      <= hit_word[37:33];
        HitChannelId   <= hit_word[32:26];
        HitLeading     <= hit_word[25:13];
        HitTrailing    <= hit_word[12:0];
        HitEventNumber <= hdr_evt;
      end

      FrameDone <= ftr_fire;
      if (ftr_fire) begin
        FrameOk          <= ~(frame_err | e2 | e3 | e4);
        FrameEventNumber <= hdr_evt;
        FrameDataLength  <= hdr_len;
      end

      ErrPulse <= err_any;
      if (err_any) ErrCode <= err_code;

      if (ClrCounters) begin
        FrameCount <= 32'd0;
        ErrCount   <= 16'd0;
      end else begin
        if (ftr_fire) FrameCount <= FrameCount + 32'd1;
        if (err_any && ErrCount != 16'hFFFF) ErrCount <= ErrCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sitcp_frame_checker.sv
module tb_sitcp_frame_checker;

  logic        Clk;
  logic        Rst;
  logic        Enable;
  logic        ClrCounters;
  logic [7:0]  FifoRdData;
  logic        FifoEmpty;
  logic        FifoValid;
  logic        FifoRdEnb;
  logic        HitValid;
  logic [4:0]  HitAsicId;
  logic [6:0]  HitChannelId;
  logic [12:0] HitLeading;
  logic [12:0] HitTrailing;
  logic [23:0] HitEventNumber;
  logic        FrameDone;
  logic        FrameOk;
  logic [23:0] FrameEventNumber;
  logic [23:0] FrameDataLength;
  logic        ErrPulse;
  logic [2:0]  ErrCode;
  logic [31:0] FrameCount;
  logic [15:0] ErrCount;

  sitcp_frame_checker dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .ClrCounters(ClrCounters),
    .FifoRdData(FifoRdData), .FifoEmpty(FifoEmpty), .FifoValid(FifoValid),
    .FifoRdEnb(FifoRdEnb), .HitValid(HitValid), .HitAsicId(HitAsicId),
    .HitChannelId(HitChannelId), .HitLeading(HitLeading), .HitTrailing(HitTrailing),
    .HitEventNumber(HitEventNumber), .FrameDone(FrameDone), .FrameOk(FrameOk),
    .FrameEventNumber(FrameEventNumber), .FrameDataLength(FrameDataLength),
    .ErrPulse(ErrPulse), .ErrCode(ErrCode), .FrameCount(FrameCount), .ErrCount(ErrCount)
  );

`ifdef FRAME_CHECK_SEQ_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  typedef struct {
    logic [4:0]  asic;
    logic [6:0]  ch;
    logic [12:0] lead;
    logic [12:0] trail;
    logic [23:0] evt;
  } hit_t;

  typedef struct {
    logic        ok;
    logic [23:0] evt;
    logic [23:0] len;
    logic [31:0] cnt;
  } frm_t;

  typedef struct {
    logic [23:0] evt;
    logic [23:0] len;
    int          nhits;
    logic [23:0] fevt;
    bit          garbage;
    bit          ok;
    int          nerr;
    logic [2:0]  c0;
    logic [2:0]  c1;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] bq[$];
  hit_t       hq[$];
  frm_t       fq[$];
  logic [2:0] eq[$];
  vec_t       tbl[8];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  always @(posedge Clk) begin
    #1;
    if (HitValid) hq.push_back('{HitAsicId, HitChannelId, HitLeading, HitTrailing, HitEventNumber});
    if (FrameDone) fq.push_back('{FrameOk, FrameEventNumber, FrameDataLength, FrameCount});
    if (ErrPulse) eq.push_back(ErrCode);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] hdr_word(input logic [1:0] ld, input logic [23:0] evt,
                                           input logic [23:0] len);
    return {ld, 8'h5A, 2'b10, 1'b1, 17'h1ABCD, 1'b1, evt, 1'b0, len};
  endfunction

  function automatic hit_t hit_of(input int i, input logic [23:0] evt);
    hit_t h;
    h.asic  = 5'(4 + i);
    h.ch    = 7'h1C ^ 7'(i);
    h.lead  = 13'(13'h1555 + i);
    h.trail = 13'(13'h0E0 + 3 * i);
    h.evt   = evt;
    return h;
  endfunction

  function automatic logic [63:0] pack_hit(input hit_t h);
    return {2'b00, h.asic, h.ch, h.lead, h.trail, h.evt};
  endfunction

  task automatic push_word80(input logic [79:0] w);
    for (int k = 9; k >= 0; k--) bq.push_back(w[8*k +: 8]);
  endtask

  task automatic push_hit(input hit_t h);
    logic [39:0] w;
    w = {2'b00, h.asic, h.ch, h.lead, h.trail};
    for (int k = 4; k >= 0; k--) bq.push_back(w[8*k +: 8]);
  endtask

  task automatic build_frame(input logic [23:0] evt, input logic [23:0] len, input int n,
                             input logic [23:0] fevt);
    push_word80(hdr_word(2'b10, evt, len));
    for (int i = 0; i < n; i++) push_hit(hit_of(i, evt));
    push_word80(hdr_word(2'b11, fevt, len));
  endtask

  // FIFO model: rd_en seen at a rising edge yields FifoValid the next cycle.
  task automatic send(input bit gaps, input int en_drop);
    bit         pending;
    logic [7:0] nb;
    int         cyc;
    pending = 1'b0;
    nb = 8'h00;
    cyc = 0;
    while ((bq.size() > 0 || pending) && cyc < 4000) begin
      @(negedge Clk);
      FifoValid  = pending;
      FifoRdData = pending ? nb : 8'hA5;
      Enable     = !(en_drop >= 0 && cyc >= en_drop && cyc < en_drop + 6);
      FifoEmpty  = (bq.size() == 0) || (gaps && (cyc % 2 == 1));
      #1;
      pending = FifoRdEnb;
      if (pending) nb = bq.pop_front();
      cyc++;
    end
    if (cyc >= 4000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d required<4000", cyc);
    end
    @(negedge Clk);
    FifoValid  = 1'b0;
    FifoRdData = 8'hA5;
    FifoEmpty  = 1'b1;
    Enable     = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic prep();
    @(negedge Clk);
    ClrCounters = 1'b1;
    @(negedge Clk);
    ClrCounters = 1'b0;
    #1;
    chk("clr_frame_count", FrameCount, 0);
    chk("clr_err_count", ErrCount, 0);
    hq.delete();
    fq.delete();
    eq.delete();
    bq.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdenb"}, FifoRdEnb, 0);
    chk({tag, "_hitvalid"}, HitValid, 0);
    chk({tag, "_hitfields"}, {HitAsicId, HitChannelId, HitLeading, HitTrailing}, 0);
    chk({tag, "_hitevt"}, HitEventNumber, 0);
    chk({tag, "_framedone"}, FrameDone, 0);
    chk({tag, "_frameok"}, FrameOk, 0);
    chk({tag, "_frameevt"}, FrameEventNumber, 0);
    chk({tag, "_framelen"}, FrameDataLength, 0);
    chk({tag, "_errpulse"}, ErrPulse, 0);
    chk({tag, "_errcode"}, ErrCode, 0);
    chk({tag, "_framecount"}, FrameCount, 0);
    chk({tag, "_errcount"}, ErrCount, 0);
  endtask

  task automatic check_vec(input vec_t v);
    chk("hit_count", hq.size(), v.nhits);
    for (int i = 0; i < v.nhits && i < hq.size(); i++)
      chk("hit_fields", pack_hit(hq[i]), pack_hit(hit_of(i, v.evt)));
    chk("frame_done_count", fq.size(), 1);
    if (fq.size() > 0) begin
      chk("frame_ok", fq[0].ok, v.ok);
      chk("frame_evt", fq[0].evt, v.evt);
      chk("frame_len", fq[0].len, v.len);
      chk("frame_count", fq[0].cnt, 1);
    end
    chk("err_pulses", eq.size(), v.nerr);
    if (eq.size() > 0) chk("err_code0", eq[0], v.c0);
    if (eq.size() > 1) chk("err_code1", eq[1], v.c1);
    chk("err_count", ErrCount, v.nerr);
  endtask

  initial begin
    //         evt        len    n  fevt       garb ok nerr c0 c1
    tbl[0] = '{24'h000000, 24'd3, 3, 24'h000000, 1'b0, 1'b1, 0, 3'd0, 3'd0};
    tbl[1] = '{24'h000001, 24'd2, 2, 24'h000001, 1'b1, 1'b1, 0, 3'd0, 3'd0};
    tbl[2] = '{24'h000002, 24'd3, 2, 24'h000002, 1'b0, 1'b0, 1, 3'd3, 3'd0};
    tbl[3] = '{24'h000003, 24'd3, 4, 24'h000003, 1'b0, 1'b0, 2, 3'd5, 3'd3};
    tbl[4] = '{24'h000004, 24'd1, 1, 24'h0ABCDE, 1'b0, 1'b0, 1, 3'd2, 3'd0};
    tbl[5] = '{24'h000005, 24'd2, 1, 24'h000006, 1'b0, 1'b0, 1, 3'd2, 3'd0};
    tbl[6] = '{24'h000006, 24'd0, 0, 24'h000006, 1'b0, 1'b1, 0, 3'd0, 3'd0};
    tbl[7] = '{24'hFFFFFF, 24'd0, 1, 24'hFFFFFF, 1'b0, 1'b0, 2, 3'd5, 3'd3};

    Rst = 1'b0;
    Enable = 1'b1;
    ClrCounters = 1'b0;
    FifoRdData = 8'hA5;
    FifoEmpty = 1'b1;
    FifoValid = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_zero("reset");
    @(negedge Clk);
    Rst = 1'b1;

    // FifoRdEnb is a pure combination of Rst, Enable and FifoEmpty.
    @(negedge Clk);
    FifoEmpty = 1'b0;
    #1 chk("rdenb_on", FifoRdEnb, 1);
    Enable = 1'b0;
    #1 chk("rdenb_disabled", FifoRdEnb, 0);
    Enable = 1'b1;
    FifoEmpty = 1'b1;
    #1 chk("rdenb_empty", FifoRdEnb, 0);

    for (int t = 0; t < 8; t++) begin
      prep();
      if (tbl[t].garbage) begin
        bq.push_back(8'h01);
        bq.push_back(8'h3F);
        bq.push_back(8'hC5);
      end
      build_frame(tbl[t].evt, tbl[t].len, tbl[t].nhits, tbl[t].fevt);
      send(1'b0, -1);
      check_vec(tbl[t]);
    end

    // Exact latency with back-to-back bytes driven straight into the parser.
    prep();
    push_word80(hdr_word(2'b10, 24'h000040, 24'd1));
    push_hit(hit_of(0, 24'h000040));
    while (bq.size() > 1) begin
      @(negedge Clk);
      FifoValid = 1'b1;
      FifoRdData = bq.pop_front();
    end
    @(negedge Clk);
    FifoRdData = bq.pop_front();
    #1 chk("hit_before_edge", HitValid, 0);
    @(posedge Clk);
    #1 chk("hit_latency", HitValid, 1);
    chk("hit_trail_imm", HitTrailing, 13'h0E0);
    @(negedge Clk);
    FifoValid = 1'b0;
    @(posedge Clk);
    #1 chk("hit_pulse_width", HitValid, 0);
    chk("hit_fields_hold", {HitAsicId, HitChannelId, HitLeading}, {5'd4, 7'h1C, 13'h1555});
    push_word80(hdr_word(2'b11, 24'h000040, 24'd1));
    while (bq.size() > 1) begin
      @(negedge Clk);
      FifoValid = 1'b1;
      FifoRdData = bq.pop_front();
    end
    @(negedge Clk);
    FifoRdData = bq.pop_front();
    #1 chk("done_before_edge", FrameDone, 0);
    @(posedge Clk);
    #1 chk("done_latency", FrameDone, 1);
    chk("done_ok", FrameOk, 1);
    chk("done_count", FrameCount, 1);
    @(negedge Clk);
    FifoValid = 1'b0;
    FifoRdData = 8'hA5;
    @(posedge Clk);
    #1 chk("done_pulse_width", FrameDone, 0);
    repeat (2) @(negedge Clk);

    // Bad lead 01 at DATA index 0 aborts to HUNT; next frame decodes.
    prep();
    push_word80(hdr_word(2'b10, 24'h000010, 24'd2));
    push_hit(hit_of(0, 24'h000010));
    bq.push_back(8'h40);
    build_frame(24'h000011, 24'd1, 1, 24'h000011);
    send(1'b0, -1);
    chk("err1a_hits", hq.size(), 2);
    if (hq.size() > 1) chk("err1a_hit2", pack_hit(hq[1]), pack_hit(hit_of(0, 24'h000011)));
    chk("err1a_frames", fq.size(), 1);
    if (fq.size() > 0) chk("err1a_frame", {fq[0].ok, fq[0].evt, fq[0].cnt},
                           {1'b1, 24'h000011, 32'd1});
    chk("err1a_pulses", eq.size(), 1);
    if (eq.size() > 0) chk("err1a_code", eq[0], 1);
    chk("err1a_errcount", ErrCount, 1);

    // Header lead at DATA index 0 raises ERR 1 and restarts a header.
    prep();
    push_word80(hdr_word(2'b10, 24'h000020, 24'd2));
    push_hit(hit_of(0, 24'h000020));
    build_frame(24'h000021, 24'd1, 1, 24'h000021);
    send(1'b0, -1);
    chk("err1b_frames", fq.size(), 1);
    if (fq.size() > 0) chk("err1b_frame", {fq[0].ok, fq[0].evt, fq[0].len},
                           {1'b1, 24'h000021, 24'd1});
    chk("err1b_pulses", eq.size(), 1);
    if (eq.size() > 0) chk("err1b_code", eq[0], 1);

    // Event sequence 5, 6, 8.
    prep();
    build_frame(24'd5, 24'd1, 1, 24'd5);
    build_frame(24'd6, 24'd1, 1, 24'd6);
    build_frame(24'd8, 24'd1, 1, 24'd8);
    send(1'b0, -1);
    chk("seq_frames", fq.size(), 3);
    if (fq.size() == 3) begin
      chk("seq_ok_first_two", {fq[0].ok, fq[1].ok}, 2'b11);
      chk("seq_ok_third", fq[2].ok, 1 - SEQ_ON);
    end
    chk("seq_pulses", eq.size(), SEQ_ON);
    if (eq.size() > 0) chk("seq_code", eq[0], 4);
    chk("seq_errcount", ErrCount, SEQ_ON);
    chk("seq_framecount", FrameCount, 3);

    // Sequence across the 24-bit wrap is consecutive.
    prep();
    build_frame(24'hFFFFFF, 24'd1, 1, 24'hFFFFFF);
    build_frame(24'h000000, 24'd1, 1, 24'h000000);
    build_frame(24'h000001, 24'd1, 1, 24'h000001);
    send(1'b0, -1);
    chk("wrap_frames", fq.size(), 3);
    chk("wrap_pulses", eq.size(), 0);

    // Gapped FIFO and Enable dropped mid-hit: same results as gapless.
    prep();
    build_frame(tbl[0].evt, tbl[0].len, tbl[0].nhits, tbl[0].fevt);
    send(1'b1, 24);
    check_vec(tbl[0]);

    // Reset mid-frame clears everything and drops the partial frame.
    hq.delete();
    fq.delete();
    eq.delete();
    push_word80(hdr_word(2'b10, 24'h000009, 24'd3));
    push_hit(hit_of(0, 24'h000009));
    push_hit(hit_of(1, 24'h000009));
    send(1'b0, -1);
    chk("partial_hits", hq.size(), 2);
    @(negedge Clk);
    Rst = 1'b0;
    FifoEmpty = 1'b0;
    @(posedge Clk);
    #1;
    check_zero("midreset");
    @(negedge Clk);
    Rst = 1'b1;
    FifoEmpty = 1'b1;
    fq.delete();
    eq.delete();
    build_frame(24'h000030, 24'd1, 1, 24'h000030);
    send(1'b0, -1);
    chk("post_reset_frames", fq.size(), 1);
    if (fq.size() > 0) chk("post_reset_frame", {fq[0].ok, fq[0].evt, fq[0].len, fq[0].cnt},
                           {1'b1, 24'h000030, 24'd1, 32'd1});
    chk("post_reset_errs", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sitcp_frame_checker.md
# sitcp_frame_checker

Read-side consumer for the 8-bit SiTCP byte-stream FIFO. Pulls bytes whenever the FIFO is non-empty and parses them into frames: a 10-byte header, N 5-byte hit words, and a 10-byte footer. It emits decoded hits and per-frame summaries, and checks framing, footer/header consistency, data length and event-number sequence. It sits on the FIFO read clock domain, ahead of link transmission or on-board monitoring.

## Interface
- No parameters; field widths are fixed by the frame format.
- Clk  in  1  read-side clock (FIFO rd_clk)
- Rst  in  1  synchronous reset, active-low
- Enable  in  1  1 = consume FIFO; 0 = hold FifoRdEnb low, parser state retained
- ClrCounters  in  1  synchronous clear of FrameCount, ErrCount and the sequence reference
- FifoRdData  in  8  FIFO dout
- FifoEmpty  in  1  FIFO empty
- FifoValid  in  1  FIFO valid; the byte on FifoRdData is consumed when this is 1
- FifoRdEnb  out  1  FIFO rd_en = Rst & Enable & ~FifoEmpty (combinational)
- HitValid  out  1  one-cycle pulse, hit fields valid
- HitAsicId / HitChannelId / HitLeading / HitTrailing  out  5/7/13/13  decoded hit fields
- HitEventNumber  out  24  event number of the enclosing frame
- FrameDone  out  1  one-cycle pulse at the end of each footer
- FrameOk  out  1  valid with FrameDone; 1 = no error in this frame
- FrameEventNumber / FrameDataLength  out  24/24  header fields of the completed frame
- ErrPulse  out  1  one-cycle pulse per detected error
- ErrCode  out  3  valid with ErrPulse
- FrameCount  out  32  frames completed, wraps
- ErrCount  out  16  errors detected, saturates at 0xFFFF

## Operation
- Byte layout, MSB first:
  - Header: 2'b10, Addr[7:0], Mode[1:0], ZS, Empty[16:0], TW, EventNumber[23:0], Last, DataLength[23:0].
  - Hit: 2'b00, Asic[4:0], Ch[6:0], Lead[12:0], Trail[12:0].
  - Footer: same as header with lead 2'b11.
- States: HUNT, HDR, DATA, FTR. A 4-bit byte index, a 24-bit word counter and an 80-bit header shadow.
- HUNT:
  - Discard accepted bytes silently.
  - On a byte with [7:6]=2'b10, capture it as header byte 0 and move to HDR with index 1.
- HDR: shift bytes into the shadow. When byte 9 is accepted, latch the header, clear the word counter and go to DATA with index 0.
- DATA, index 0, decode [7:6] of the byte:
  - 00: start a hit word. If word count == DataLength, raise ERR 5, at most once per frame; the hit is still emitted.
  - 11: footer byte 0. Go to FTR with index 1.
  - 10: raise ERR 1, then treat the byte as header byte 0 and go to HDR with index 1.
  - 01: raise ERR 1 and go to HUNT.
- DATA: when index-4 is accepted, emit the hit, increment the word counter and return to index 0.
- FTR, after byte 9 is accepted:
  - Compare the footer's 78 bits after the lead with the header shadow. Mismatch raises ERR 2.
  - Word count != DataLength raises ERR 3.
  - Pulse FrameDone and go to DATA-wait, which is HUNT.
- Error codes: 1 = bad lead in DATA; 2 = footer/header mismatch; 3 = length mismatch at footer; 4 = event sequence; 5 = word overflow.
- Multiple errors in one cycle: ErrPulse fires once with the lowest code; ErrCount increments by 1.
- FrameOk = 0 if any error occurred since the header was latched.
- An error that aborts a frame (ERR 1) yields no FrameDone.
- ClrCounters takes priority over any simultaneous increment.

## Timing
- FifoRdEnb is combinational. Bytes are qualified only by FifoValid; no byte count is assumed from rd_en.
- HitValid and its fields are registered, 1 cycle after the FifoValid cycle carrying hit byte 4. Fields hold until the next hit.
- FrameDone, FrameOk, ErrPulse(2/3/4) and FrameCount++ occur 1 cycle after footer byte 9.
- ERR 1 and ERR 5 pulse 1 cycle after the offending byte.
- Back-to-back bytes are sustained with no bubbles: 1 byte per Clk.
- Reset (Rst=0): state HUNT, index 0, and all outputs 0, including counters, ErrCode and the hit and frame fields. Reset mid-frame discards the partial frame.
- Enable=0 mid-frame: parsing resumes where it stopped. A byte already in flight (FifoValid) is still consumed.

## Configuration
- FRAME_CHECK_SEQ_EN defined:
  - After reset or ClrCounters, the first completed frame sets the reference.
  - Each later footer requires EventNumber == previous + 1, modulo 2^24, else ERR 4.
  - The reference is always updated to the current frame.
- Undefined: no sequence check and ERR 4 is never produced.

## Test plan
- Reset, then a frame with event 0, DataLength 3 and 3 hits (Asic 4, Ch 0x1C, Lead 0x1555, Trail 0x0E0) -> 3 HitValid pulses with those fields, FrameDone with FrameOk=1, FrameDataLength=3, FrameCount=1, ErrCount=0.
- Garbage bytes 0x01, 0x3F, 0xC5 before a valid frame -> silently discarded, frame decoded, no ErrPulse.
- Frame with DataLength 3 but 2 hits -> FrameDone with FrameOk=0, ErrCode=3. With 4 hits -> ErrCode=5 at the 4th hit byte 0, then ErrCode=3 at the footer; ErrCount=2.
- Footer event number differs from header -> ErrCode=2, FrameOk=0.
- Byte 0x40 at DATA index 0 -> ErrCode=1, state HUNT, no FrameDone; next valid frame decodes OK.
- With FRAME_CHECK_SEQ_EN, events 5, 6, 8 -> ErrCode=4 on the third frame only. Without the macro -> no error.
- FIFO empty toggled every other cycle and Enable dropped mid-hit -> hit fields identical to the gapless run. Rst low mid-frame -> all outputs 0 and the partial frame is dropped.
